alu_nibble_sequencer: RTL and testbench

Multi-cycle controller that runs a WIDTH-bit ALU operation through a single external 4-bit ALU slice (carry-lookahead slice with cin/less/set/cout), one nibble per cycle, LSB nibble first. Carry is registered between nibbles. The block latches operands, sequences the slice, assembles the result and generates zero/cout/done. It sits between the register-file read stage and write-back, as an area-saving alternative to a full-width ALU.

---
 rtl/alu_nibble_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a WIDTH-bit AND/OR/ADD/SUB/SLT through one external
// 4-bit ALU slice, one nibble per cycle (LSB first), carry registered between nibbles.
// Optional macro SLT_OVF_EN adds an 'overflow' output and makes SLT a signed compare.
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
`ifdef SLT_OVF_EN
    output logic             overflow,
`endif
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic [3:0]       slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_n;
    logic             is_arith, is_slt, supported, last;
    logic             slt_bit;

    assign is_slt    = (op_q == OP_SLT);
    assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || is_slt;
    assign supported = is_arith || (op_q == OP_AND) || (op_q == OP_OR);
    assign last      = (idx == LAST);

`ifdef SLT_OVF_EN
    logic ovf_n;
    // Carry into the MSB is recovered from the sum bit and the (possibly inverted) operand MSBs.
    assign ovf_n   = is_arith & (slice_set ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ op_q[2] ^ slice_cout);
    assign slt_bit = slice_set ^ ovf_n;
`else
    assign slt_bit = slice_set;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Slice drive and next result image for the current nibble
    always_comb begin
        slice_a    = '0;
        slice_b    = '0;
        slice_cin  = 1'b0;
        slice_less = 1'b0;
        slice_op   = '0;
        res_n      = result;
        if (state == RUN) begin
            slice_cin = carry;
            slice_op  = !supported ? OP_AND : (is_slt ? OP_SUB : op_q);
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) begin
                    slice_a = a_q[4*i +: 4];
                    slice_b = b_q[4*i +: 4];
                    if (!supported)  res_n[4*i +: 4] = 4'h0;
                    else if (!is_slt) res_n[4*i +: 4] = slice_result;
                end
            end
            // SLT result is decided only once the top nibble's sign is known.
            if (is_slt && last) begin
                res_n    = '0;
                res_n[0] = slt_bit;
            end
        end
    end

    // Operand latch, nibble sequencing and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            carry  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            zero   <= 1'b1;
            cout   <= 1'b0;
`ifdef SLT_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        idx   <= '0;
                        carry <= (op == OP_SUB) || (op == OP_SLT);
                    end
                end
                RUN: begin
                    result <= res_n;
                    carry  <= slice_cout;
                    idx    <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        zero <= (res_n == '0);
                        cout <= is_arith & slice_cout;
`ifdef SLT_OVF_EN
                        overflow <= ovf_n;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed self-checking bench for alu_nibble_sequencer (WIDTH=16) with a behavioural 4-bit slice.
module tb_alu_nibble_sequencer;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clk, reset, start;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ready, busy, done, zero, cout, overflow;
    logic [15:0] result;
    logic [3:0]  slice_a, slice_b, slice_result;
    logic        slice_cin, slice_less, slice_cout, slice_set;
    logic [2:0]  slice_op;
    logic [4:0]  sum5;

    int n_checks = 0;
    int n_fail   = 0;

`ifndef SLT_OVF_EN
    assign overflow = 1'b0;
`endif

    alu_nibble_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout),
`ifdef SLT_OVF_EN
        .overflow(overflow),
`endif
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_less(slice_less),
        .slice_op(slice_op), .slice_result(slice_result), .slice_cout(slice_cout),
        .slice_set(slice_set)
    );

    // Behavioural 4-bit slice
    always_comb begin
        sum5 = 5'h0;
        case (slice_op)
            3'b000:  sum5 = {1'b0, slice_a & slice_b};
            3'b001:  sum5 = {1'b0, slice_a | slice_b};
            3'b010:  sum5 = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};
            3'b110:  sum5 = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'h0, slice_cin};
            default: sum5 = 5'h0;
        endcase
    end
    assign slice_result = sum5[3:0];
    assign slice_cout   = sum5[4];
    assign slice_set    = sum5[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic z, output logic c,
                         output logic ov, output logic [2:0] sop, output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        sop = slice_op;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero; c = cout; ov = overflow;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = OP_ADD; a = 16'h1111; b = 16'h2222;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1)      begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h exp 0000", result); end
        n_checks++; if (zero !== 1'b1)       begin n_fail++; $display("FAIL reset_zero got %b exp 1", zero); end
        n_checks++; if (cout !== 1'b0)       begin n_fail++; $display("FAIL reset_cout got %b exp 0", cout); end
        n_checks++; if ({slice_a, slice_b, slice_cin, slice_less, slice_op} !== 13'h0)
            begin n_fail++; $display("FAIL reset_slice got %h/%h/%b/%b/%b exp all 0", slice_a, slice_b, slice_cin, slice_less, slice_op); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_latency();
        logic [3:0] esa [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
        logic [3:0] esb [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
        logic       ecin[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 16'h00FF; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL lat_ready k=%0d got %b exp 0", k, ready); end
            n_checks++; if (done !== ((k == 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL lat_done k=%0d got %b", k, done); end
            if (k < 4) begin
                n_checks++;
                if ({slice_a, slice_b, slice_cin, slice_op} !== {esa[k], esb[k], ecin[k], OP_ADD}) begin
                    n_fail++;
                    $display("FAIL lat_slice k=%0d got a=%h b=%h cin=%b op=%b exp a=%h b=%h cin=%b op=010",
                             k, slice_a, slice_b, slice_cin, slice_op, esa[k], esb[k], ecin[k]);
                end
                @(posedge clk); #1;
            end
        end
        n_checks++; if (result !== 16'h0100) begin n_fail++; $display("FAIL lat_result got %h exp 0100", result); end
        n_checks++; if (zero !== 1'b0)       begin n_fail++; $display("FAIL lat_zero got %b exp 0", zero); end
        n_checks++; if (cout !== 1'b0)       begin n_fail++; $display("FAIL lat_cout got %b exp 0", cout); end
        @(posedge clk); #1;
        n_checks++; if ({ready, done, slice_op} !== 5'b10000) begin n_fail++; $display("FAIL lat_idle got ready=%b done=%b op=%b exp 1 0 000", ready, done, slice_op); end
    endtask

    task automatic test_arith();
        logic [15:0] r; logic z, c, ov; logic [2:0] sop; int lat;
        do_op(OP_ADD, 16'hFFFF, 16'h0001, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'h0000, 1'b1, 1'b1}) begin n_fail++; $display("FAIL add_wrap got r=%h z=%b c=%b exp 0000 1 1", r, z, c); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_wrap_latency got %0d exp 4", lat); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL add_wrap_ovf got %b exp 0", ov); end
        do_op(OP_SUB, 16'h1234, 16'h1234, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'h0000, 1'b1, 1'b1}) begin n_fail++; $display("FAIL sub_eq got r=%h z=%b c=%b exp 0000 1 1", r, z, c); end
        n_checks++; if (sop !== OP_SUB) begin n_fail++; $display("FAIL sub_slice_op got %b exp 110", sop); end
        do_op(OP_ADD, 16'h7FFF, 16'h0001, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'h8000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_sign got r=%h z=%b c=%b exp 8000 0 0", r, z, c); end
`ifdef SLT_OVF_EN
        n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL add_sign_ovf got %b exp 1", ov); end
`endif
    endtask

    task automatic test_logic();
        logic [15:0] r; logic z, c, ov; logic [2:0] sop; int lat;
        do_op(OP_AND, 16'hF0F0, 16'h3C3C, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c, ov} !== {16'h3030, 3'b000}) begin n_fail++; $display("FAIL and got r=%h z=%b c=%b ov=%b exp 3030 0 0 0", r, z, c, ov); end
        n_checks++; if (sop !== OP_AND) begin n_fail++; $display("FAIL and_slice_op got %b exp 000", sop); end
        do_op(OP_OR, 16'hF0F0, 16'h3C3C, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'hFCFC, 2'b00}) begin n_fail++; $display("FAIL or got r=%h z=%b c=%b exp FCFC 0 0", r, z, c); end
        n_checks++; if (sop !== OP_OR) begin n_fail++; $display("FAIL or_slice_op got %b exp 001", sop); end
    endtask

    task automatic test_slt();
        logic [15:0] r; logic z, c, ov; logic [2:0] sop; int lat;
        do_op(OP_SLT, 16'h0003, 16'h0005, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'h0001, 2'b00}) begin n_fail++; $display("FAIL slt_lt got r=%h z=%b c=%b exp 0001 0 0", r, z, c); end
        n_checks++; if (sop !== OP_SUB) begin n_fail++; $display("FAIL slt_slice_op got %b exp 110", sop); end
        do_op(OP_SLT, 16'h0005, 16'h0003, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'h0000, 2'b11}) begin n_fail++; $display("FAIL slt_gt got r=%h z=%b c=%b exp 0000 1 1", r, z, c); end
        do_op(OP_SLT, 16'h7FFF, 16'h8000, r, z, c, ov, sop, lat);
`ifdef SLT_OVF_EN
        n_checks++; if ({r, z, c, ov} !== {16'h0000, 3'b101}) begin n_fail++; $display("FAIL slt_ovf got r=%h z=%b c=%b ov=%b exp 0000 1 0 1", r, z, c, ov); end
`else
        n_checks++; if ({r, z, c} !== {16'h0001, 2'b00}) begin n_fail++; $display("FAIL slt_raw got r=%h z=%b c=%b exp 0001 0 0", r, z, c); end
`endif
    endtask

    task automatic test_unsupported();
        logic [15:0] r; logic z, c, ov; logic [2:0] sop; int lat;
        do_op(OP_OR, 16'h00F0, 16'h000F, r, z, c, ov, sop, lat);
        n_checks++; if (r !== 16'h00FF) begin n_fail++; $display("FAIL unsup_pre got %h exp 00FF", r); end
        do_op(3'b011, 16'hFFFF, 16'hFFFF, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c, ov} !== {16'h0000, 3'b100}) begin n_fail++; $display("FAIL unsup got r=%h z=%b c=%b ov=%b exp 0000 1 0 0", r, z, c, ov); end
        n_checks++; if (sop !== 3'b000) begin n_fail++; $display("FAIL unsup_slice_op got %b exp 000", sop); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL unsup_latency got %0d exp 4", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 16'h00FF; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if ({done, result} !== {1'b1, 16'h0100}) begin n_fail++; $display("FAIL b2b_first got done=%b r=%h exp 1 0100", done, result); end
        @(posedge clk); #1;
        n_checks++; if ({ready, done, result} !== {2'b10, 16'h0100}) begin n_fail++; $display("FAIL b2b_gap got ready=%b done=%b r=%h exp 1 0 0100", ready, done, result); end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_second_latency got %0d exp 4", lat); end
        n_checks++; if (result !== 16'h0003) begin n_fail++; $display("FAIL b2b_second got %h exp 0003", result); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] r; logic z, c, ov; logic [2:0] sop; int lat;
        int pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; op = OP_ADD; a = 16'h0F0F; b = 16'h0101;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if ({ready, busy, done, zero, result} !== {4'b1001, 16'h0000}) begin
            n_fail++; $display("FAIL midrst got ready=%b busy=%b done=%b zero=%b r=%h exp 1 0 0 1 0000", ready, busy, done, zero, result);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_done_pulses got %0d exp 0", pulses); end
        do_op(OP_ADD, 16'h0001, 16'h0001, r, z, c, ov, sop, lat);
        n_checks++; if ({r, z, c} !== {16'h0002, 2'b00}) begin n_fail++; $display("FAIL midrst_fresh got r=%h z=%b c=%b exp 0002 0 0", r, z, c); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; a = 16'h0; b = 16'h0;
        test_reset();
        test_latency();
        test_arith();
        test_logic();
        test_slt();
        test_unsupported();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
